// File: rtl/adc_multi_read.sv
// adc_multi_read: reads N_CH serial ADCs sharing one CS/SCLK, one frame per request or continuously
// Ports: clk, rst (async, active-low); start_in single-frame request; cont_in continuous mode;
//        data_in[N_CH] serial lines; adc_cs_out/adc_sclk_out ADC control; busy_out in CONV/QUIET;
//        valid_out one-cycle frame-done pulse; error_out leading-zero violations;
//        read_out channel i at [i*DATA_W +: DATA_W]; frame_cnt_out completed-frame count.
module adc_multi_read #(
    parameter int N_CH       = 4,
    parameter int DATA_W     = 12,
    parameter int LEAD_ZEROS = 4,
    parameter int CLK_DIV    = 2,
    parameter int QUIET_CYC  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_in,
    input  logic                     cont_in,
    input  logic [N_CH-1:0]          data_in,
    output logic                     adc_cs_out,
    output logic                     adc_sclk_out,
    output logic                     busy_out,
    output logic                     valid_out,
    output logic [N_CH-1:0]          error_out,
    output logic [N_CH*DATA_W-1:0]   read_out,
    output logic [15:0]              frame_cnt_out
);
    localparam int F  = LEAD_ZEROS + DATA_W;
    localparam int BW = $clog2(F + 1);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int QW = $clog2(QUIET_CYC + 1);
    localparam logic [1:0] IDLE = 2'd0, CONV = 2'd1, QUIET = 2'd2;

    logic [1:0]               state_q, state_d;
    logic                     cs_q, cs_d, sclk_q, sclk_d, valid_q, valid_d;
    logic [DW-1:0]            div_q, div_d;
    logic [BW-1:0]            bit_q, bit_d;
    logic [QW-1:0]            quiet_q, quiet_d;
    logic [N_CH*DATA_W-1:0]   shift_q, shift_d, read_q, read_d;
    logic [N_CH-1:0]          err_acc_q, err_acc_d, error_q, error_d;
    logic [15:0]              frame_cnt_q, frame_cnt_d;
    logic                     quiet_done, start_conv;

    assign quiet_done = quiet_q == QW'(QUIET_CYC - 1);
    // A frame starts from IDLE on any request, or back-to-back from the last QUIET cycle in continuous mode
    assign start_conv = (state_q == IDLE && (start_in || cont_in)) ||
                        (state_q == QUIET && quiet_done && cont_in);

    always_comb begin
        state_d     = state_q;
        cs_d        = cs_q;
        sclk_d      = sclk_q;
        valid_d     = 1'b0;
        div_d       = div_q;
        bit_d       = bit_q;
        quiet_d     = quiet_q;
        shift_d     = shift_q;
        err_acc_d   = err_acc_q;
        read_d      = read_q;
        error_d     = error_q;
        frame_cnt_d = frame_cnt_q;
        if (start_conv) begin
            state_d   = CONV;
            cs_d      = 1'b0;
            sclk_d    = 1'b0;
            div_d     = '0;
            bit_d     = '0;
            err_acc_d = '0;
        end else if (state_q == QUIET) begin
            quiet_d = quiet_q + 1'b1;
            if (quiet_done) state_d = IDLE;
        end else if (state_q == CONV) begin
            if (div_q != DW'(CLK_DIV - 1)) begin
                div_d = div_q + 1'b1;
            end else if (sclk_q && bit_q == BW'(F)) begin
                // End of the last high half-period: publish the whole frame at once
                state_d     = QUIET;
                cs_d        = 1'b1;
                sclk_d      = 1'b1;
                quiet_d     = '0;
                valid_d     = 1'b1;
                read_d      = shift_q;
                error_d     = err_acc_q;
                frame_cnt_d = frame_cnt_q + 16'd1;
            end else begin
                div_d  = '0;
                sclk_d = ~sclk_q;
                // Sample on the edge that drives SCLK high
                if (!sclk_q) begin
                    bit_d = bit_q + 1'b1;
                    if (bit_q < BW'(LEAD_ZEROS))
                        err_acc_d = err_acc_q | data_in;
                    else
                        for (int i = 0; i < N_CH; i++)
                            shift_d[i*DATA_W +: DATA_W] = {shift_q[i*DATA_W +: DATA_W-1], data_in[i]};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cs_q        <= 1'b1;
            sclk_q      <= 1'b1;
            valid_q     <= 1'b0;
            div_q       <= '0;
            bit_q       <= '0;
            quiet_q     <= '0;
            shift_q     <= '0;
            err_acc_q   <= '0;
            read_q      <= '0;
            error_q     <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cs_q        <= cs_d;
            sclk_q      <= sclk_d;
            valid_q     <= valid_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            quiet_q     <= quiet_d;
            shift_q     <= shift_d;
            err_acc_q   <= err_acc_d;
            read_q      <= read_d;
            error_q     <= error_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign adc_cs_out    = cs_q;
    assign adc_sclk_out  = sclk_q;
    assign busy_out      = state_q != IDLE;
    assign valid_out     = valid_q;
    assign error_out     = error_q;
    assign read_out      = read_q;
    assign frame_cnt_out = frame_cnt_q;
endmodule

// File: tb/tb_adc_multi_read.sv
// tb_adc_multi_read: directed self-checking bench for adc_multi_read (2 channels, CLK_DIV=1)
module tb_adc_multi_read;
    logic        clk = 1'b0;
    logic        rst, start_in, cont_in;
    logic [1:0]  data_in;
    logic        adc_cs_out, adc_sclk_out, busy_out, valid_out;
    logic [1:0]  error_out;
    logic [23:0] read_out;
    logic [15:0] frame_cnt_out;
    logic [15:0] p0, p1;
    int          k = 0;
    int          checks = 0, failures = 0;
    logic [15:0] exp_cnt = 16'd0;

    always #5 clk = ~clk;

    adc_multi_read #(.N_CH(2), .DATA_W(12), .LEAD_ZEROS(4), .CLK_DIV(1), .QUIET_CYC(2)) dut (
        .clk(clk), .rst(rst), .start_in(start_in), .cont_in(cont_in), .data_in(data_in),
        .adc_cs_out(adc_cs_out), .adc_sclk_out(adc_sclk_out), .busy_out(busy_out),
        .valid_out(valid_out), .error_out(error_out), .read_out(read_out),
        .frame_cnt_out(frame_cnt_out)
    );

    // ADC model: presents frame bit k (MSB first) after k SCLK rises since CS fell
    always @(negedge adc_cs_out) k = 0;
    always @(posedge adc_sclk_out) if (!adc_cs_out) #1 k = k + 1;
    assign data_in = (k < 16) ? {p1[15-k], p0[15-k]} : 2'b00;

    task automatic run_frame(input logic [15:0] a, input logic [15:0] b, output int lat);
        p0 = a;
        p1 = b;
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        lat = 1;
        while (valid_out !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        checks++; if (adc_cs_out !== 1'b1) begin failures++; $display("FAIL reset_cs got=%b exp=1", adc_cs_out); end
        checks++; if (adc_sclk_out !== 1'b1) begin failures++; $display("FAIL reset_sclk got=%b exp=1", adc_sclk_out); end
        checks++; if (busy_out !== 1'b0 || valid_out !== 1'b0) begin failures++; $display("FAIL reset_busy_valid got=%b%b exp=00", busy_out, valid_out); end
        checks++; if (read_out !== 24'h0 || error_out !== 2'b00 || frame_cnt_out !== 16'h0) begin
            failures++; $display("FAIL reset_regs got=%h/%b/%h exp=0/00/0", read_out, error_out, frame_cnt_out); end
    endtask

    task automatic test_zero_frame;
        int lat;
        run_frame(16'h0000, 16'h0000, lat);
        exp_cnt++;
        checks++; if (lat !== 33) begin failures++; $display("FAIL zero_latency got=%0d exp=33", lat); end
        checks++; if (read_out !== 24'h000000 || error_out !== 2'b00) begin failures++; $display("FAIL zero_data got=%h/%b exp=000000/00", read_out, error_out); end
        checks++; if (frame_cnt_out !== exp_cnt) begin failures++; $display("FAIL zero_cnt got=%h exp=%h", frame_cnt_out, exp_cnt); end
        checks++; if (adc_cs_out !== 1'b1 || busy_out !== 1'b1) begin failures++; $display("FAIL zero_quiet got=%b%b exp=11", adc_cs_out, busy_out); end
        @(negedge clk);
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL zero_pulse got=%b exp=0", valid_out); end
        repeat (3) @(negedge clk);
        checks++; if (busy_out !== 1'b0) begin failures++; $display("FAIL zero_idle got=%b exp=0", busy_out); end
    endtask

    task automatic test_patterns;
        int lat;
        run_frame(16'h0FFF, 16'h0AAA, lat);
        exp_cnt++;
        checks++; if (lat !== 33) begin failures++; $display("FAIL pat_latency got=%0d exp=33", lat); end
        checks++; if (read_out !== 24'hAAAFFF || error_out !== 2'b00) begin failures++; $display("FAIL pat_data got=%h/%b exp=aaafff/00", read_out, error_out); end
        checks++; if (frame_cnt_out !== exp_cnt) begin failures++; $display("FAIL pat_cnt got=%h exp=%h", frame_cnt_out, exp_cnt); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_lead_error;
        int lat;
        run_frame(16'h0000, 16'h1555, lat);
        exp_cnt++;
        checks++; if (error_out !== 2'b10) begin failures++; $display("FAIL lead_err got=%b exp=10", error_out); end
        checks++; if (read_out !== 24'h555000) begin failures++; $display("FAIL lead_data got=%h exp=555000", read_out); end
        checks++; if (frame_cnt_out !== exp_cnt) begin failures++; $display("FAIL lead_cnt got=%h exp=%h", frame_cnt_out, exp_cnt); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_continuous;
        int cyc = 0, nval = 0, last_v = 0, cs_hi = 0, extra = 0;
        logic [23:0] held;
        held = read_out;
        p0 = 16'h0123;
        p1 = 16'h0456;
        cont_in = 1'b1;
        while (nval < 3 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (adc_cs_out) cs_hi++;
            if (cyc == 20) begin
                checks++; if (read_out !== held) begin failures++; $display("FAIL cont_hold got=%h exp=%h", read_out, held); end
            end
            if (valid_out) begin
                nval++;
                exp_cnt++;
                checks++; if (frame_cnt_out !== exp_cnt) begin failures++; $display("FAIL cont_cnt got=%h exp=%h", frame_cnt_out, exp_cnt); end
                checks++; if (read_out !== 24'h456123) begin failures++; $display("FAIL cont_data got=%h exp=456123", read_out); end
                if (nval > 1) begin
                    checks++; if (cyc - last_v !== 34) begin failures++; $display("FAIL cont_period got=%0d exp=34", cyc - last_v); end
                    checks++; if (cs_hi !== 2) begin failures++; $display("FAIL cont_cs_gap got=%0d exp=2", cs_hi); end
                end
                last_v = cyc;
                cs_hi = 0;
                if (nval == 3) cont_in = 1'b0;
            end
        end
        checks++; if (nval !== 3) begin failures++; $display("FAIL cont_timeout got=%0d exp=3", nval); end
        cont_in = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (valid_out) extra++;
        end
        checks++; if (extra !== 0 || busy_out !== 1'b0) begin failures++; $display("FAIL cont_stop got=%0d/%b exp=0/0", extra, busy_out); end
    endtask

    task automatic test_ignore_start;
        int cyc = 0, nval = 0, vcyc = -10, lat = 0;
        p0 = 16'h0ABC;
        p1 = 16'h0321;
        start_in = 1'b1;
        while (cyc < 120) begin
            @(negedge clk);
            cyc++;
            start_in = (cyc == 10) || (cyc == vcyc);
            if (cyc == vcyc + 1) start_in = 1'b0;
            if (valid_out) begin
                nval++;
                lat = cyc;
                vcyc = cyc;
                start_in = 1'b1;
                exp_cnt++;
                checks++; if (read_out !== 24'h321ABC) begin failures++; $display("FAIL ign_data got=%h exp=321abc", read_out); end
            end
        end
        start_in = 1'b0;
        checks++; if (nval !== 1) begin failures++; $display("FAIL ign_count got=%0d exp=1", nval); end
        checks++; if (lat !== 33) begin failures++; $display("FAIL ign_latency got=%0d exp=33", lat); end
        checks++; if (busy_out !== 1'b0 || frame_cnt_out !== exp_cnt) begin failures++; $display("FAIL ign_end got=%b/%h exp=0/%h", busy_out, frame_cnt_out, exp_cnt); end
    endtask

    task automatic test_wrap;
        int lat;
        force dut.frame_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt_q;
        @(negedge clk);
        checks++; if (frame_cnt_out !== 16'hFFFF) begin failures++; $display("FAIL wrap_preload got=%h exp=ffff", frame_cnt_out); end
        run_frame(16'h0FFF, 16'h0000, lat);
        exp_cnt = 16'h0000;
        checks++; if (frame_cnt_out !== exp_cnt || valid_out !== 1'b1) begin failures++; $display("FAIL wrap_cnt got=%h exp=0000", frame_cnt_out); end
        checks++; if (read_out !== 24'h000FFF) begin failures++; $display("FAIL wrap_data got=%h exp=000fff", read_out); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int nval = 0, lows = 0;
        p0 = 16'h0F0F;
        p1 = 16'h00F0;
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        repeat (13) @(negedge clk);
        checks++; if (adc_sclk_out !== 1'b1 || k !== 7) begin failures++; $display("FAIL mid_rise7 got=%b/%0d exp=1/7", adc_sclk_out, k); end
        rst = 1'b0;
        #1;
        checks++; if (adc_cs_out !== 1'b1 || adc_sclk_out !== 1'b1) begin failures++; $display("FAIL mid_pins got=%b%b exp=11", adc_cs_out, adc_sclk_out); end
        checks++; if (read_out !== 24'h0 || busy_out !== 1'b0 || frame_cnt_out !== 16'h0) begin
            failures++; $display("FAIL mid_regs got=%h/%b/%h exp=0/0/0", read_out, busy_out, frame_cnt_out); end
        @(negedge clk);
        rst = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (valid_out) nval++;
            if (!adc_cs_out) lows++;
        end
        checks++; if (nval !== 0 || lows !== 0) begin failures++; $display("FAIL mid_idle got=%0d/%0d exp=0/0", nval, lows); end
    endtask

    initial begin
        rst = 1'b0;
        start_in = 1'b0;
        cont_in = 1'b0;
        p0 = 16'h0;
        p1 = 16'h0;
        repeat (3) @(negedge clk);
        test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        test_zero_frame;
        test_patterns;
        test_lead_error;
        test_continuous;
        test_ignore_start;
        test_wrap;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/adc_multi_read.md
ADC_MULTI_READ -- requirements
Module: adc_multi_read

Interface
REQ-001 Parameter N_CH, default 4, number of serial ADC data lines sharing one CS and SCLK.
REQ-002 Parameter DATA_W, default 12, data bits per channel per frame.
REQ-003 Parameter LEAD_ZEROS, default 4, leading zero bits per frame ahead of data.
REQ-004 Parameter CLK_DIV, default 2 (min 1), clk cycles per SCLK half-period.
REQ-005 Parameter QUIET_CYC, default 2 (min 1), clk cycles CS held high between frames.
REQ-006 clk  input  1  system clock; all logic on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-low.
REQ-008 start_in  input  1  single-frame request, sampled in IDLE only.
REQ-009 cont_in  input  1  continuous mode; frames repeat while high.
REQ-010 data_in  input  N_CH  serial data, bit i from ADC i, MSB-first.
REQ-011 adc_cs_out  output  1  chip select, active-low.
REQ-012 adc_sclk_out  output  1  serial clock, idles high.
REQ-013 busy_out  output  1  high in CONV and QUIET.
REQ-014 valid_out  output  1  one-cycle pulse, frame complete.
REQ-015 error_out  output  N_CH  per-channel leading-zero violation, updated with valid_out.
REQ-016 read_out  output  N_CH*DATA_W  channel i at bits [i*DATA_W +: DATA_W].
REQ-017 frame_cnt_out  output  16  completed-frame count, wraps.

Function
REQ-018 FSM states IDLE, CONV, QUIET; F = LEAD_ZEROS+DATA_W SCLK periods per frame.
REQ-019 IDLE -> CONV when start_in or cont_in high; adc_cs_out low from next cycle.
REQ-020 In CONV SCLK period = 2*CLK_DIV cycles: low for first CLK_DIV, high for second.
REQ-021 data_in sampled on the clk edge that drives SCLK high; k-th rising edge captures bit k.
REQ-022 All N_CH channels shifted in parallel; first LEAD_ZEROS bits checked, remaining DATA_W bits shifted MSB-first.
REQ-023 After F rising SCLK edges (2*CLK_DIV*F cycles in CONV): CS high, SCLK high, enter QUIET.
REQ-024 valid_out high exactly the first QUIET cycle; read_out, error_out, frame_cnt_out update on that same cycle.
REQ-025 Latency: valid_out asserted 1+2*CLK_DIV*F cycles after the edge sampling the start.
REQ-026 error_out[i]=1 if any leading bit of channel i was 1; read_out[i] still updated with data bits.
REQ-027 read_out, error_out hold between valid pulses; no partial updates mid-frame.
REQ-028 QUIET lasts QUIET_CYC cycles, then CONV if cont_in high at last QUIET cycle, else IDLE.
REQ-029 start_in ignored while busy_out high; no queuing.
REQ-030 cont_in falling mid-frame: current frame completes normally, then IDLE.
REQ-031 frame_cnt_out increments by 1 per valid_out; 16'hFFFF -> 16'h0000.
REQ-032 Start in IDLE requires no QUIET before first frame.

Reset
REQ-033 rst low asynchronously forces: IDLE, adc_cs_out=1, adc_sclk_out=1, busy_out=0, valid_out=0, error_out=0, read_out=0, frame_cnt_out=0, counters/shift registers cleared.
REQ-034 Reset mid-frame aborts it: no valid_out for that frame; after release stay IDLE until start_in or cont_in.

Verification (N_CH=2, DATA_W=12, LEAD_ZEROS=4, CLK_DIV=1, QUIET_CYC=2)
REQ-035 start_in pulse, both lines 0 for 16 bits -> valid_out 33 cycles after start edge, read_out=24'h000000, error_out=2'b00, frame_cnt_out=1.
REQ-036 ch0 0000_1111_1111_1111, ch1 0000_1010_1010_1010 -> read_out[11:0]=12'hFFF, read_out[23:12]=12'hAAA, error_out=2'b00.
REQ-037 ch1 000 then 13 alternating bits starting 1 (1010...), ch0 all zeros -> error_out=2'b10, read_out[23:12]=12'h555, read_out[11:0]=0.
REQ-038 cont_in=1 for 3 frames -> CS high exactly 2 cycles between frames, valid_out every 34 cycles, frame_cnt_out 1,2,3; preload path: 65536 frames wrap count to 0.
REQ-039 rst low during SCLK rise 7 -> CS=1, SCLK=1, read_out=0 same cycle; no valid_out after release until new start_in.
REQ-040 start_in pulsed mid-frame and in QUIET with cont_in=0 -> ignored; exactly one valid_out, then IDLE.
